// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks.
package mips_pipe_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned ZERO_REG   = 0;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    LU_WAIT = 1'b1
  } lu_state_t;

endpackage

// File: rtl/load_use_hazard_ctrl_if.sv
// ID/EX hazard bundle: dependency inputs from the pipeline and the control outputs back to it.
interface load_use_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
) ();

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_mem_read;
  logic              mem_busy;
  logic              branch_taken;

  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              pipe_hold;
  logic              lu_active;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rt, ex_mem_read, mem_busy, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, lu_active
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rt, ex_mem_read, mem_busy, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, lu_active
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the performance counters.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/load_use_hazard_ctrl.sv
// Load-use hazard controller: multi-cycle bubble insertion, memory-busy freeze,
// taken-branch IF/ID flush and a saturating stall-cycle counter.
module load_use_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned LOAD_LAT    = 1,
  parameter bit          ZERO_EXEMPT = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  load_use_hazard_ctrl_if.slave hz,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     stall_cnt
);

  lu_state_t  state, state_nxt;
  logic [3:0] rem, rem_nxt;

  logic hit;
  logic zero_dst;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, lu_active;

  assign zero_dst = ZERO_EXEMPT && (hz.ex_rt == REG_AW'(ZERO_REG));
  assign hit = hz.ex_mem_read
             & ((hz.id_uses_rs & (hz.ex_rt == hz.id_rs)) |
                (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)))
             & ~zero_dst;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rem_nxt     = rem;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    lu_active   = 1'b0;

    if (hz.mem_busy) begin
      // Whole pipeline frozen; FSM and rem keep their values.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      lu_active  = (state == LU_WAIT);
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            lu_active   = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = LU_WAIT;
              rem_nxt   = 4'(LOAD_LAT - 1);
            end
          end else if (hz.branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
        LU_WAIT: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          lu_active   = 1'b1;
          rem_nxt     = rem - 1'b1;
          if (rem == 4'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Reset forces a safe bubble state regardless of inputs.
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      pipe_hold   = 1'b0;
      lu_active   = 1'b0;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.pipe_hold   = pipe_hold;
  assign hz.lu_active   = lu_active;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (~pc_write),
    .clr     (cnt_clr),
    .cnt     (stall_cnt)
  );

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Directed bench: two controller instances (LOAD_LAT=1 and LOAD_LAT=3) share the same stimulus.
module tb_load_use_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] s1, s3;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  load_use_hazard_ctrl_if #(.REG_AW(5)) if1 ();
  load_use_hazard_ctrl_if #(.REG_AW(5)) if3 ();

  load_use_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .ZERO_EXEMPT(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .hz(if1.slave), .cnt_clr(cnt_clr), .stall_cnt(s1));
  load_use_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .ZERO_EXEMPT(1'b1), .CNT_W(16)) dut3 (
    .clk(clk), .reset_n(reset_n), .hz(if3.slave), .cnt_clr(cnt_clr), .stall_cnt(s3));

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, lu_active}
  logic [5:0] o1, o3;
  assign o1 = {if1.pc_write, if1.ifid_write, if1.ifid_flush, if1.idex_bubble, if1.pipe_hold, if1.lu_active};
  assign o3 = {if3.pc_write, if3.ifid_write, if3.ifid_flush, if3.idex_bubble, if3.pipe_hold, if3.lu_active};

  localparam logic [5:0] FREE  = 6'b110000;
  localparam logic [5:0] LUST  = 6'b000101;
  localparam logic [5:0] BRFL  = 6'b111000;
  localparam logic [5:0] BUSYI = 6'b000010;
  localparam logic [5:0] BUSYW = 6'b000011;
  localparam logic [5:0] RSTV  = 6'b000100;

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic [4:0] ert, input logic mr, input logic mb, input logic br);
    if1.id_rs = rs; if1.id_rt = rt; if1.id_uses_rs = urs; if1.id_uses_rt = urt;
    if1.ex_rt = ert; if1.ex_mem_read = mr; if1.mem_busy = mb; if1.branch_taken = br;
    if3.id_rs = rs; if3.id_rt = rt; if3.id_uses_rs = urs; if3.id_uses_rt = urt;
    if3.ex_rt = ert; if3.ex_mem_read = mr; if3.mem_busy = mb; if3.branch_taken = br;
  endtask

  task automatic idle_in();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_cnt();
    idle_in();
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_in();
    @(negedge clk);
    checks++; if (o1 !== RSTV) begin errors++; $display("FAIL reset_out1 got=%b want=%b", o1, RSTV); end
    checks++; if (o3 !== RSTV) begin errors++; $display("FAIL reset_out3 got=%b want=%b", o3, RSTV); end
    checks++; if (s3 !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", s3); end
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if (o3 !== FREE) begin errors++; $display("FAIL post_reset_out got=%b want=%b", o3, FREE); end
    checks++; if (s1 !== 16'd0) begin errors++; $display("FAIL post_reset_cnt got=%0d want=0", s1); end
    next_cycle();
  endtask

  task automatic test_latency();
    clear_cnt();
    drive(5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (o1 !== LUST) begin errors++; $display("FAIL lat_c0_ll1 got=%b want=%b", o1, LUST); end
    checks++; if (o3 !== LUST) begin errors++; $display("FAIL lat_c0_ll3 got=%b want=%b", o3, LUST); end
    next_cycle();
    idle_in();
    @(negedge clk);
    checks++; if (o1 !== FREE) begin errors++; $display("FAIL lat_c1_ll1 got=%b want=%b", o1, FREE); end
    checks++; if (o3 !== LUST) begin errors++; $display("FAIL lat_c1_ll3 got=%b want=%b", o3, LUST); end
    next_cycle();
    @(negedge clk);
    checks++; if (o3 !== LUST) begin errors++; $display("FAIL lat_c2_ll3 got=%b want=%b", o3, LUST); end
    next_cycle();
    @(negedge clk);
    checks++; if (o3 !== FREE) begin errors++; $display("FAIL lat_c3_ll3 got=%b want=%b", o3, FREE); end
    checks++; if (s1 !== 16'd1) begin errors++; $display("FAIL lat_cnt_ll1 got=%0d want=1", s1); end
    checks++; if (s3 !== 16'd3) begin errors++; $display("FAIL lat_cnt_ll3 got=%0d want=3", s3); end
    next_cycle();
  endtask

  task automatic test_no_hazard();
    drive(5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (o3 !== FREE) begin errors++; $display("FAIL zero_exempt got=%b want=%b", o3, FREE); end
    next_cycle();
    drive(5'd5, 5'd7, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (o1 !== FREE) begin errors++; $display("FAIL unused_rs got=%b want=%b", o1, FREE); end
    next_cycle();
    drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (o1 !== FREE) begin errors++; $display("FAIL not_load got=%b want=%b", o1, FREE); end
    next_cycle();
    drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (o1 !== LUST) begin errors++; $display("FAIL rt_hit got=%b want=%b", o1, LUST); end
    idle_in();
    repeat (4) next_cycle();
  endtask

  task automatic test_mem_busy();
    clear_cnt();
    drive(5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    next_cycle();
    idle_in();
    @(negedge clk);
    checks++; if (o3 !== LUST) begin errors++; $display("FAIL busy_c1_ll3 got=%b want=%b", o3, LUST); end
    next_cycle();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (o3 !== BUSYW) begin errors++; $display("FAIL busy_c2_ll3 got=%b want=%b", o3, BUSYW); end
    checks++; if (o1 !== BUSYI) begin errors++; $display("FAIL busy_c2_ll1 got=%b want=%b", o1, BUSYI); end
    next_cycle();
    @(negedge clk);
    checks++; if (o3 !== BUSYW) begin errors++; $display("FAIL busy_c3_ll3 got=%b want=%b", o3, BUSYW); end
    next_cycle();
    idle_in();
    @(negedge clk);
    checks++; if (o3 !== LUST) begin errors++; $display("FAIL busy_c4_ll3 got=%b want=%b", o3, LUST); end
    next_cycle();
    @(negedge clk);
    checks++; if (o3 !== FREE) begin errors++; $display("FAIL busy_c5_ll3 got=%b want=%b", o3, FREE); end
    checks++; if (s3 !== 16'd5) begin errors++; $display("FAIL busy_cnt_ll3 got=%0d want=5", s3); end
    checks++; if (s1 !== 16'd3) begin errors++; $display("FAIL busy_cnt_ll1 got=%0d want=3", s1); end
    next_cycle();
  endtask

  task automatic test_branch();
    drive(5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (o1 !== LUST) begin errors++; $display("FAIL br_stall_ll1 got=%b want=%b", o1, LUST); end
    next_cycle();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (o1 !== BRFL) begin errors++; $display("FAIL br_free_ll1 got=%b want=%b", o1, BRFL); end
    checks++; if (o3 !== LUST) begin errors++; $display("FAIL br_wait_ll3 got=%b want=%b", o3, LUST); end
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (o3 !== BRFL) begin errors++; $display("FAIL br_after_ll3 got=%b want=%b", o3, BRFL); end
    next_cycle();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (o1 !== BUSYI) begin errors++; $display("FAIL br_busy got=%b want=%b", o1, BUSYI); end
    next_cycle();
    idle_in();
    next_cycle();
  endtask

  task automatic test_reset_mid_stall();
    drive(5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    next_cycle();
    idle_in();
    reset_n = 1'b0;
    #1;
    checks++; if (o3 !== RSTV) begin errors++; $display("FAIL midrst_out got=%b want=%b", o3, RSTV); end
    checks++; if (s3 !== 16'd0) begin errors++; $display("FAIL midrst_cnt got=%0d want=0", s3); end
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (o3 !== FREE) begin errors++; $display("FAIL midrst_release got=%b want=%b", o3, FREE); end
    next_cycle();
    @(negedge clk);
    checks++; if (o3 !== FREE) begin errors++; $display("FAIL midrst_residual got=%b want=%b", o3, FREE); end
    next_cycle();
  endtask

  task automatic test_saturation();
    clear_cnt();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    checks++; if (s1 !== 16'hFFFF) begin errors++; $display("FAIL sat_ll1 got=%h want=ffff", s1); end
    checks++; if (s3 !== 16'hFFFF) begin errors++; $display("FAIL sat_ll3 got=%h want=ffff", s3); end
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
    checks++; if (s3 !== 16'd0) begin errors++; $display("FAIL clr_over_inc got=%0d want=0", s3); end
    next_cycle();
    checks++; if (s3 !== 16'd1) begin errors++; $display("FAIL count_after_clr got=%0d want=1", s3); end
    idle_in();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_no_hazard();
    test_mem_busy();
    test_branch();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
